garage_door_ctrl_v2: RTL
========================

// Module: garage_door_ctrl_v2
// PURPOSE
//  Next-generation garage door motor controller: Moore FSM driving up/down motor enables from limit switches and a push-button.
//  Adds button edge detection, stop-mid-travel, obstruction auto-reverse, motor dead-time, auto-close and move-timeout fault.
//  Sits between debounced door sensors/button and the motor driver; one door per instance.
// PARAMETERS
//  MOVE_TIMEOUT  4096  max cycles in MV_UP/MV_DN before FAULT (>=2)
//  AUTOCLOSE_CYC 0     cycles in OPEN before auto close; 0 disables auto-close
//  DEAD_CYC      8     motor-off cycles in PAUSE before any direction start (>=1)
//  TMR_W         clog2(max(MOVE_TIMEOUT,AUTOCLOSE_CYC,DEAD_CYC))+1, derived localparam, not user-set
// PORTS
//  clk       in  1  clock
//  rst_n     in  1  async active-low reset
//  activate  in  1  button level, synchronous/debounced upstream; only rising edge acts
//  up_max    in  1  fully-open limit switch
//  down_max  in  1  fully-closed limit switch
//  obstruct  in  1  beam-break, high = obstruction present
//  fault_clr in  1  1-cycle pulse, leaves FAULT
//  up_m      out 1  motor up enable
//  down_m    out 1  motor down enable
//  fault     out 1  high while in FAULT
//  state_o   out 3  current state encoding, for debug/status
// BEHAVIOUR
//  Reset: state=SETTLE, act_q=0, timer=0, last_dir=0(up), pend_dir=0; up_m=down_m=fault=0.
//  act_edge = activate & ~act_q; act_q registered every cycle. One cycle from input edge to state change.
//  Outputs decode current state only: up_m=(MV_UP), down_m=(MV_DN), fault=(FAULT). up_m&down_m never 1.
//  Timer: one shared counter, cleared on every state change, else increments, saturates at all-ones.
//  Global: up_max&down_max in any state except FAULT -> FAULT (highest priority).
//  SETTLE: down_max -> CLOSED; up_max -> OPEN; neither -> STOPPED.
//  CLOSED: act_edge -> pend_dir=up, PAUSE.
//  OPEN: act_edge -> pend_dir=down, PAUSE; else AUTOCLOSE_CYC!=0 & timer==AUTOCLOSE_CYC-1 & !obstruct -> pend_dir=down, PAUSE.
//        obstruct high clears timer (auto-close restarts after beam clears).
//  MV_UP (last_dir=up): priority up_max -> OPEN; timer==MOVE_TIMEOUT-1 -> FAULT; act_edge -> STOPPED.
//  MV_DN (last_dir=down): priority down_max -> CLOSED; obstruct -> pend_dir=up, PAUSE (auto-reverse);
//        timer==MOVE_TIMEOUT-1 -> FAULT; act_edge -> STOPPED.
//  STOPPED: act_edge -> pend_dir=~last_dir, PAUSE.
//  PAUSE: motors off; at timer==DEAD_CYC-1: pend_dir=up -> MV_UP; pend_dir=down & !obstruct -> MV_DN;
//         pend_dir=down & obstruct -> STOPPED. act_edge during PAUSE ignored.
//  FAULT: motors off; fault_clr -> SETTLE; all other inputs ignored.
//  Limit already asserted on entry (e.g. up_max when entering MV_UP) -> exits next cycle; one-cycle motor pulse permitted.
//  Async reset mid-move drops motors immediately (outputs are decode of reset state).
//  state_o encoding: SETTLE=0 CLOSED=1 OPEN=2 MV_UP=3 MV_DN=4 STOPPED=5 PAUSE=6 FAULT=7.
// STRUCTURE
//  Shared include gdc_defs.vh: state encoding localparams, direction constants (DIR_UP=0, DIR_DN=1).
//  One sub-module gdc_timer #(TMR_W): clear, saturating up-count, count output; FSM, edge detect, dir regs in top.
// TESTING  (MOVE_TIMEOUT=20, AUTOCLOSE_CYC=30, DEAD_CYC=3)
//  Reset with down_max=1 -> CLOSED; activate held high 50 cycles -> exactly one open cycle (PAUSE 3, MV_UP), no re-trigger.
//  MV_UP, up_max rises after 10 cycles -> OPEN, up_m low next cycle; no activity -> PAUSE at OPEN cycle 30, then MV_DN.
//  MV_DN, obstruct pulse 1 cycle at move cycle 5 -> down_m low next cycle, 3 idle cycles, up_m high.
//  MV_DN, act_edge -> STOPPED; act_edge -> PAUSE then MV_UP (direction reversed); act_edge again -> STOPPED.
//  MV_UP, no limit for 20 cycles -> FAULT, fault=1, motors 0; activate ignored; fault_clr with up_max=0,down_max=0 -> SETTLE -> STOPPED.
//  up_max=down_max=1 in OPEN -> FAULT next cycle; rst_n low mid MV_DN -> down_m=0 asynchronously.

Source files
------------

// File: rtl/garage_door_ctrl_v2_pkg.sv
// Shared definitions for the garage door controller.
//   state_e   : FSM states; the encoding is visible on state_o for status/debug
//   DIR_UP/DN : travel direction encoding used by last_dir / pend_dir
//   tmr_width : timer width large enough for the biggest terminal count,
//               plus one bit of headroom so the counter saturates harmlessly
package garage_door_ctrl_v2_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_CLOSED  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_MV_UP   = 3'd3,
        ST_MV_DN   = 3'd4,
        ST_STOPPED = 3'd5,
        ST_PAUSE   = 3'd6,
        ST_FAULT   = 3'd7
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/garage_door_ctrl_v2_timer.sv
// gdc_timer: shared state-dwell counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (takes priority over counting)
//   count      : cycles since last clear, saturating at all-ones
module gdc_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [TMR_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (count != {TMR_W{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/garage_door_ctrl_v2.sv
// garage_door_ctrl_v2: Moore FSM driving a garage door motor.
//   clk, rst_n         : clock, async active-low reset
//   activate           : push-button level (debounced); rising edge acts
//   up_max, down_max   : fully-open / fully-closed limit switches
//   obstruct           : beam-break, high = obstruction
//   fault_clr          : pulse, leaves FAULT
//   up_m, down_m       : motor enables (never both high)
//   fault              : high while in FAULT
//   state_o            : current state encoding
// Every direction start passes through PAUSE so the motor sees at least
// DEAD_CYC off cycles before it is driven again.
module garage_door_ctrl_v2
    import garage_door_ctrl_v2_pkg::*;
#(
    parameter int MOVE_TIMEOUT  = 4096,
    parameter int AUTOCLOSE_CYC = 0,
    parameter int DEAD_CYC      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       activate,
    input  logic       up_max,
    input  logic       down_max,
    input  logic       obstruct,
    input  logic       fault_clr,
    output logic       up_m,
    output logic       down_m,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int TMR_W = tmr_width(MOVE_TIMEOUT, AUTOCLOSE_CYC, DEAD_CYC);

    localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYC - 1);
    localparam logic [TMR_W-1:0] AC_LAST   =
        (AUTOCLOSE_CYC == 0) ? '0 : TMR_W'(AUTOCLOSE_CYC - 1);
    localparam logic             AC_EN     = (AUTOCLOSE_CYC != 0);

    state_e           state, nxt;
    logic             act_q;
    logic             last_dir, last_nxt;
    logic             pend_dir, pend_nxt;
    logic             act_edge;
    logic             tmr_clr;
    logic [TMR_W-1:0] tmr;

    assign act_edge = activate & ~act_q;

    gdc_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .count (tmr)
    );

    always_comb begin
        nxt      = state;
        pend_nxt = pend_dir;
        last_nxt = last_dir;

        // Both limits at once means a broken sensor: latch into FAULT.
        if (state != ST_FAULT && up_max && down_max) begin
            nxt = ST_FAULT;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (down_max)    nxt = ST_CLOSED;
                    else if (up_max) nxt = ST_OPEN;
                    else             nxt = ST_STOPPED;
                end
                ST_CLOSED: begin
                    if (act_edge) begin
                        nxt      = ST_PAUSE;
                        pend_nxt = DIR_UP;
                    end
                end
                ST_OPEN: begin
                    if (act_edge || (AC_EN && tmr == AC_LAST && !obstruct)) begin
                        nxt      = ST_PAUSE;
                        pend_nxt = DIR_DN;
                    end
                end
                ST_MV_UP: begin
                    if (up_max)                nxt = ST_OPEN;
                    else if (tmr == MOVE_LAST) nxt = ST_FAULT;
                    else if (act_edge)         nxt = ST_STOPPED;
                end
                ST_MV_DN: begin
                    if (down_max) begin
                        nxt = ST_CLOSED;
                    end else if (obstruct) begin
                        nxt      = ST_PAUSE;   // auto-reverse
                        pend_nxt = DIR_UP;
                    end else if (tmr == MOVE_LAST) begin
                        nxt = ST_FAULT;
                    end else if (act_edge) begin
                        nxt = ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    if (act_edge) begin
                        nxt      = ST_PAUSE;
                        pend_nxt = ~last_dir;
                    end
                end
                ST_PAUSE: begin
                    if (tmr == DEAD_LAST) begin
                        if (pend_dir == DIR_UP) nxt = ST_MV_UP;
                        else if (!obstruct)     nxt = ST_MV_DN;
                        else                    nxt = ST_STOPPED;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) nxt = ST_SETTLE;
                end
                default: nxt = ST_FAULT;
            endcase
        end

        if (nxt == ST_MV_UP) last_nxt = DIR_UP;
        if (nxt == ST_MV_DN) last_nxt = DIR_DN;
    end

    // A beam across the opening holds the auto-close countdown at zero.
    assign tmr_clr = (nxt != state) || (state == ST_OPEN && obstruct);

    // Outputs are registered decodes of the next state, so they always
    // equal a decode of the current state (and of reset during reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SETTLE;
            act_q    <= 1'b0;
            last_dir <= DIR_UP;
            pend_dir <= DIR_UP;
            up_m     <= 1'b0;
            down_m   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= nxt;
            act_q    <= activate;
            last_dir <= last_nxt;
            pend_dir <= pend_nxt;
            up_m     <= (nxt == ST_MV_UP);
            down_m   <= (nxt == ST_MV_DN);
            fault    <= (nxt == ST_FAULT);
        end
    end

    assign state_o = state;

endmodule
